// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its clients.
package instruction_fetch_unit_pkg;

    localparam int                WORD_W        = 32;
    localparam int                DEFAULT_DEPTH = 4;
    localparam logic [WORD_W-1:0] RESET_PC      = 32'h0;

    // FILL: nothing buffered and nothing in flight; RUN: otherwise.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } ifu_state_e;

    // One prefetch buffer entry: the word and the address it came from.
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundles the RAM read port, the redirect input and the decode handshake.
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    logic [WORD_W-1:0] mem_a;
    logic              mem_rw;
    logic              mem_rd;
    logic [WORD_W-1:0] mem_dout;
    logic              br_valid;
    logic [WORD_W-1:0] br_target;
    logic              instr_valid;
    logic              instr_ready;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] instr_pc;

    // Fetch unit side.
    modport master (
        output mem_a, mem_rw, mem_rd, instr_valid, instr, instr_pc,
        input  mem_dout, br_valid, br_target, instr_ready
    );

    // Memory / execute / decode side.
    modport slave (
        input  mem_a, mem_rw, mem_rd, instr_valid, instr, instr_pc,
        output mem_dout, br_valid, br_target, instr_ready
    );

endinterface

// File: rtl/instruction_fetch_unit_fifo.sv
// Prefetch buffer: DEPTH entries of {pc, word}, flush has priority over push/pop.
module instruction_fifo
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_pop;
    logic          do_push;

    // A push into a full buffer is accepted when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage carries data only, so it is never reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: word-addressed prefetcher in front of a 1-cycle RAM,
// with a small buffer toward decode and a redirect input from execute.
module instruction_fetch_unit #(
    parameter int                                              DEPTH    = instruction_fetch_unit_pkg::DEFAULT_DEPTH,
    parameter logic [instruction_fetch_unit_pkg::WORD_W-1:0] RESET_PC = instruction_fetch_unit_pkg::RESET_PC
) (
    input  logic                        clk,
    input  logic                        rst,
    instruction_fetch_unit_if.master    bus
);
    import instruction_fetch_unit_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;

    ifu_state_e        state_q;
    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] inflight_pc_q;
    logic              inflight_q;
    logic [CW-1:0]     fifo_count;
    fetch_entry_t      head;
    fetch_entry_t      push_data;
    logic              pop;
    logic              push;
    logic              issue;
    logic [OW-1:0]     occupancy;
    logic [OW-1:0]     count_after;

    // A pop offered alongside a redirect is voided by the flush inside the buffer.
    assign pop  = bus.instr_valid & bus.instr_ready;
    // The response arriving during a redirect belongs to the old stream and is dropped.
    assign push = inflight_q & ~bus.br_valid;

    // Slots already promised (buffered + in flight) minus the one leaving now.
    assign occupancy   = OW'(fifo_count) + OW'(inflight_q) - OW'(pop);
    assign issue       = ~rst & ~bus.br_valid & (occupancy < OW'(DEPTH));
    assign count_after = OW'(fifo_count) + OW'(push) - OW'(pop);

    assign push_data = '{pc: inflight_pc_q, word: bus.mem_dout};

    instruction_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (bus.br_valid),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    // Fetch PC, in-flight flag and FILL/RUN state advance together.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            state_q    <= ST_FILL;
        end else begin
            inflight_q <= issue;
            if (bus.br_valid) begin
                pc_q <= bus.br_target;
            end else if (issue) begin
                pc_q <= pc_q + WORD_W'(1);
            end
            case (state_q)
                ST_FILL: if (issue) state_q <= ST_RUN;
                ST_RUN:  if (bus.br_valid || ((count_after == '0) && !issue)) state_q <= ST_FILL;
                default: state_q <= ST_FILL;
            endcase
        end
    end

    // Address tag for the response that returns next cycle.
    always_ff @(posedge clk) begin
        if (issue) inflight_pc_q <= pc_q;
    end

    assign bus.mem_a       = pc_q;
    assign bus.mem_rw      = 1'b0;
    assign bus.mem_rd      = issue;
    assign bus.instr_valid = (fifo_count != '0) & ~rst;
    assign bus.instr       = head.word;
    assign bus.instr_pc    = head.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: synchronous RAM model,
// scoreboard of expected fetch addresses, redirect vector table.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    typedef struct {
        logic [31:0] target;
        int          n;
        logic [31:0] exp_last;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return 32'hE3A0_0001 + a;
    endfunction

    // RAM model with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_dout <= ram_word(bus.mem_a);
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic        s_valid, s_rd, s_xfer;
    logic [31:0] s_pc, s_word, s_a, last_pc;
    int          n_iss;
    vec_t        vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // One clock cycle: sample at negedge, score any transfer, return just after posedge.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        s_valid = bus.instr_valid;
        s_rd    = bus.mem_rd;
        s_pc    = bus.instr_pc;
        s_word  = bus.instr;
        s_a     = bus.mem_a;
        s_xfer  = !rst && bus.instr_valid && bus.instr_ready && !bus.br_valid;
        chk("mem_rw", {31'b0, bus.mem_rw}, 32'h0);
        if (s_xfer) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_xfer: got pc %h, required no transfer", s_pc);
            end else begin
                e = exp_q.pop_front();
                chk("xfer_pc", s_pc, e);
                chk("xfer_word", s_word, ram_word(e));
                last_pc = s_pc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("xfer_taken", {31'b0, s_xfer}, 32'h1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_0040, 3, 32'h0000_0042};
        vecs[1] = '{32'hFFFF_FFFE, 4, 32'h0000_0001};
        vecs[2] = '{32'h0000_1000, 3, 32'h0000_1002};
        vecs[3] = '{32'h0000_0007, 2, 32'h0000_0008};

        rst             = 1'b1;
        bus.br_valid    = 1'b0;
        bus.br_target   = 32'h0;
        bus.instr_ready = 1'b1;
        last_pc         = 32'h0;
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("rst_valid", {31'b0, s_valid}, 32'h0);
        chk("rst_rd", {31'b0, s_rd}, 32'h0);
        chk("rst_mem_a", s_a, 32'h0);

        // Fill from reset with decode always ready.
        rst = 1'b0;
        tick();
        chk("fill_rd_c0", {31'b0, s_rd}, 32'h1);
        chk("fill_valid_c0", {31'b0, s_valid}, 32'h0);
        tick();
        chk("fill_valid_c1", {31'b0, s_valid}, 32'h0);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i));
        stream(8);
        bus.instr_ready = 1'b0;

        // Let the buffer fill, then reset it away.
        repeat (4) tick();
        chk("full_valid", {31'b0, s_valid}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_valid_c0", {31'b0, s_valid}, 32'h0);
        n_iss = int'(s_rd);
        tick();
        chk("post_rst_valid_c1", {31'b0, s_valid}, 32'h0);
        n_iss += int'(s_rd);
        tick();
        chk("post_rst_valid_c2", {31'b0, s_valid}, 32'h1);
        chk("post_rst_pc_c2", s_pc, 32'h0);
        n_iss += int'(s_rd);
        for (int i = 3; i < 10; i++) begin
            tick();
            n_iss += int'(s_rd);
        end
        chk("stall_issues", 32'(n_iss), 32'd4);
        chk("stall_rd_off", {31'b0, s_rd}, 32'h0);
        chk("stall_head_pc", s_pc, 32'h0);
        chk("stall_head_word", s_word, 32'hE3A0_0001);
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(i));
        bus.instr_ready = 1'b1;
        stream(5);
        bus.instr_ready = 1'b0;

        // Redirect with words buffered and a fetch in flight, decode stalled.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("prefill_pc", s_pc, 32'h0);
        chk("prefill_rd", {31'b0, s_rd}, 32'h0);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(i));
        bus.instr_ready = 1'b1;
        stream(3);
        bus.instr_ready = 1'b0;
        bus.br_valid    = 1'b1;
        bus.br_target   = 32'h40;
        tick();
        chk("redir_head_pc", s_pc, 32'h3);
        chk("redir_rd", {31'b0, s_rd}, 32'h0);
        bus.br_valid = 1'b0;
        tick();
        chk("redir_valid_c1", {31'b0, s_valid}, 32'h0);
        tick();
        chk("redir_valid_c2", {31'b0, s_valid}, 32'h0);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h40 + 32'(i));
        bus.instr_ready = 1'b1;
        stream(3);

        // Redirects landing on a cycle where decode is popping.
        for (int v = 0; v < 4; v++) begin
            bus.br_valid  = 1'b1;
            bus.br_target = vecs[v].target;
            tick();
            chk("br_pop_valid", {31'b0, s_valid}, 32'h1);
            chk("br_pop_rd", {31'b0, s_rd}, 32'h0);
            bus.br_valid = 1'b0;
            tick();
            chk("br_gap_c1", {31'b0, s_valid}, 32'h0);
            tick();
            chk("br_gap_c2", {31'b0, s_valid}, 32'h0);
            for (int i = 0; i < vecs[v].n; i++) exp_q.push_back(vecs[v].target + 32'(i));
            stream(vecs[v].n);
            chk("br_last_pc", last_pc, vecs[v].exp_last);
        end
        bus.instr_ready = 1'b0;
        repeat (2) tick();
        chk("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
